// File: rtl/pairing_host_loader.sv
// Host sequencer for BN254_pairing: loads L3 words into all banks, runs, streams results.
// Define LOADER_TIMEOUT_EN to add a busy-fall timeout with a one-cycle err pulse.
`timescale 1ns/1ps
module pairing_host_loader #(
   parameter int         ADD_DIV  = 4,
   parameter int         LIMB_W   = 64,
   parameter int         CARRY_W  = 8,
   parameter int         FP_W     = 320,
   parameter int         OUT_W    = 289,
   parameter logic [8:0] RES_BASE = 9'h10,
   parameter int         RES_CNT  = 12,
   parameter int         RD_LAT   = 2,
   parameter int         SETTLE   = 100
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [3:0]                           n_func_cfg,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [6:0]                           in_addr,
   input  logic [FP_W-1:0]                      in_data,
   input  logic                                 in_last,
   output logic                                 extin_en,
   output logic [8:0]                           extin_addr,
   output logic [ADD_DIV*(LIMB_W+CARRY_W)-1:0]  extin_data,
   output logic                                 run,
   output logic [3:0]                           n_func,
   input  logic                                 busy,
   output logic [8:0]                           extout_addr,
   input  logic [OUT_W-1:0]                     extout_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [OUT_W-1:0]                     out_data,
   output logic [3:0]                           out_idx,
   output logic                                 out_last,
`ifdef LOADER_TIMEOUT_EN
   output logic                                 err,
`endif
   output logic                                 job_busy
);

   localparam int L3_W  = LIMB_W + CARRY_W;
   localparam int DW    = ADD_DIV * L3_W;
   localparam int CNT_W = 25;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WRITE, S_RUN,
      S_RISE, S_FALL, S_READ, S_PRES
   } state_t;

   state_t             state_q;
   logic [1:0]         bank_q;
   logic               last_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [3:0]         idx_q;
   logic               in_ready_q;
   logic               wen_q;
   logic [8:0]         waddr_q;
   logic [DW-1:0]      wdata_q;
   logic               run_q;
   logic [3:0]         nfunc_q;
   logic [8:0]         raddr_q;
   logic               ovalid_q;
   logic [OUT_W-1:0]   odata_q;
   logic               olast_q;
   logic               jbusy_q;
   logic [DW-1:0]      l3_d;
   logic               unused_hi;

   // Limbs carry zero: each 72-bit slot is {8'b0, 64-bit value}
   always_comb begin
      l3_d = '0;
      for (int i = 0; i < ADD_DIV; i++)
         l3_d[i*L3_W +: LIMB_W] = in_data[i*LIMB_W +: LIMB_W];
   end

   assign unused_hi = ^in_data[FP_W-1:ADD_DIV*LIMB_W];

`ifdef LOADER_TIMEOUT_EN
   logic err_q;
   assign err = err_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         bank_q     <= '0;
         last_q     <= 1'b0;
         cnt_q      <= '0;
         idx_q      <= '0;
         in_ready_q <= 1'b1;
         wen_q      <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         run_q      <= 1'b0;
         nfunc_q    <= '0;
         raddr_q    <= '0;
         ovalid_q   <= 1'b0;
         odata_q    <= '0;
         olast_q    <= 1'b0;
         jbusy_q    <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
      end else begin
`ifdef LOADER_TIMEOUT_EN
         err_q <= 1'b0;
`endif
         unique case (state_q)
            S_IDLE, S_LOAD: begin
               if (in_valid) begin
                  if (state_q == S_IDLE) begin
                     nfunc_q <= n_func_cfg;
                     jbusy_q <= 1'b1;
                  end
                  in_ready_q <= 1'b0;
                  wen_q      <= 1'b1;
                  waddr_q    <= {2'b00, in_addr};
                  wdata_q    <= l3_d;
                  last_q     <= in_last;
                  bank_q     <= '0;
                  state_q    <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (bank_q == 2'd3) begin
                  wen_q <= 1'b0;
                  if (last_q) begin
                     run_q   <= 1'b1;
                     state_q <= S_RUN;
                  end else begin
                     in_ready_q <= 1'b1;
                     state_q    <= S_LOAD;
                  end
               end else begin
                  bank_q       <= bank_q + 2'd1;
                  waddr_q[8:7] <= bank_q + 2'd1;
               end
            end
            S_RUN: begin
               run_q   <= 1'b0;
               cnt_q   <= '0;
               state_q <= S_RISE;
            end
            S_RISE: begin
               if (busy || cnt_q == CNT_W'(SETTLE - 1)) begin
                  cnt_q   <= '0;
                  state_q <= S_FALL;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_FALL: begin
               if (!busy) begin
                  raddr_q <= RES_BASE;
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= S_READ;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
`ifdef LOADER_TIMEOUT_EN
                  if (cnt_q == CNT_W'(25'h0FF_FFFF)) begin
                     err_q      <= 1'b1;
                     jbusy_q    <= 1'b0;
                     in_ready_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end
`endif
               end
            end
            S_READ: begin
               if (cnt_q == CNT_W'(RD_LAT)) begin
                  odata_q  <= extout_data;
                  ovalid_q <= 1'b1;
                  olast_q  <= (idx_q == 4'(RES_CNT - 1));
                  state_q  <= S_PRES;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_PRES: begin
               if (out_ready) begin
                  ovalid_q <= 1'b0;
                  olast_q  <= 1'b0;
                  if (idx_q == 4'(RES_CNT - 1)) begin
                     jbusy_q    <= 1'b0;
                     in_ready_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     idx_q   <= idx_q + 4'd1;
                     raddr_q <= raddr_q + 9'd1;
                     cnt_q   <= '0;
                     state_q <= S_READ;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign extin_en    = wen_q;
   assign extin_addr  = waddr_q;
   assign extin_data  = wdata_q;
   assign run         = run_q;
   assign n_func      = nfunc_q;
   assign extout_addr = raddr_q;
   assign out_valid   = ovalid_q;
   assign out_data    = odata_q;
   assign out_idx     = idx_q;
   assign out_last    = olast_q;
   assign job_busy    = jbusy_q;

endmodule
